seg_scan_decoder: RTL and testbench

//  Receive-side decoder for the multiplexed 4-digit seven-segment bus the stopwatch drives.

---
 rtl/seg_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Receive-side decoder for a multiplexed 4-digit seven-segment bus.
//   Registers the segment/anode lines, accepts a digit only after it has
//   been stable for STABLE_CYC samples (rejects scan-transition ghosting),
//   collects the four slots into shadow registers and publishes them
//   together as one frame. Also flags illegal anode patterns (scan_err)
//   and a dead bus (scan_stall).
//   Optional feature: define SEG_DECODE_HEX_EN to decode the A-F glyphs;
//   without it those glyphs are reported as invalid (digit 0xF).
module seg_scan_decoder #(
   parameter int STABLE_CYC  = 4,       // >= 2
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 200000,
   parameter int TO_W        = 18
) (
   input  logic        clk,
   input  logic        rst,             // asynchronous, active-low
   input  logic [7:0]  seven_segment,   // [6:0]={g..a}, [7]=dp, active-low
   input  logic [3:0]  anode,           // active-low slot select
   output logic [15:0] digits,
   output logic [3:0]  dp,
   output logic [3:0]  blank,
   output logic [3:0]  invalid,
   output logic        frame_valid,
   output logic        frame_changed,
   output logic        scan_err,
   output logic        scan_stall
);

   localparam logic [0:0] ST_COLLECT = 1'b0;
   localparam logic [0:0] ST_PUBLISH = 1'b1;

   typedef struct packed {
      logic [3:0] digit;
      logic       dp;
      logic       blank;
      logic       invalid;
   } slot_t;

   // Segment pattern (active-low) to digit/flags.
   function automatic slot_t decode(input logic [7:0] seg);
      slot_t s;
      s.digit   = 4'h0;
      s.dp      = ~seg[7];
      s.blank   = 1'b0;
      s.invalid = 1'b0;
      case (seg[6:0])
         7'h40: s.digit = 4'h0;
         7'h79: s.digit = 4'h1;
         7'h24: s.digit = 4'h2;
         7'h30: s.digit = 4'h3;
         7'h19: s.digit = 4'h4;
         7'h12: s.digit = 4'h5;
         7'h02: s.digit = 4'h6;
         7'h78: s.digit = 4'h7;
         7'h00: s.digit = 4'h8;
         7'h10: s.digit = 4'h9;
         7'h7F: s.blank = 1'b1;
`ifdef SEG_DECODE_HEX_EN
         7'h08: s.digit = 4'hA;
         7'h03: s.digit = 4'hB;
         7'h46: s.digit = 4'hC;
         7'h21: s.digit = 4'hD;
         7'h06: s.digit = 4'hE;
         7'h0E: s.digit = 4'hF;
`endif
         default: begin
            s.digit   = 4'hF;
            s.invalid = 1'b1;
         end
      endcase
      return s;
   endfunction

   logic [7:0]       seg_q, seg_p;
   logic [3:0]       an_q, an_p;
   logic [CNT_W-1:0] stab_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [0:0]       state;
   logic [3:0]       mask;
   slot_t            shadow [4];
   logic             pend_valid;
   logic [1:0]       pend_slot;
   slot_t            pend_data;

   logic       an_multi, an_onehot, same, accept;
   logic [3:0] an_sel;
   logic [1:0] acc_slot;
   slot_t      acc_data;
   logic       apply_pend, apply_acc, go_publish;
   logic [3:0] mask_nxt;
   logic [15:0] pub_digits;
   logic [3:0]  pub_dp, pub_blank, pub_invalid;

   // Decode the registered sample and decide whether this cycle accepts a digit.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      acc_slot  = 2'd0;
      an_sel    = ~an_q;
      an_multi  = |(an_sel & (an_sel - 4'd1));
      an_onehot = (an_sel != 4'd0) && !an_multi;
      same      = (seg_q == seg_p) && (an_q == an_p);
      accept    = same && (stab_cnt == CNT_W'(STABLE_CYC - 1)) && an_onehot;
      case (an_sel)
         4'b0010: acc_slot = 2'd1;
         4'b0100: acc_slot = 2'd2;
         4'b1000: acc_slot = 2'd3;
         default: acc_slot = 2'd0;
      endcase
      acc_data = decode(seg_q);
   end

   // Work out mask growth and whether the frame is complete.
   always_comb begin
      apply_pend = (state == ST_COLLECT) && pend_valid;
      apply_acc  = (state == ST_COLLECT) && accept;
      mask_nxt   = mask;
      if (apply_pend) mask_nxt[pend_slot] = 1'b1;
      if (apply_acc)  mask_nxt[acc_slot]  = 1'b1;
      go_publish = (apply_pend || apply_acc) && (mask_nxt == 4'hF);
      for (int k = 0; k < 4; k++) begin
         pub_digits[4*k +: 4] = shadow[k].digit;
         pub_dp[k]            = shadow[k].dp;
         pub_blank[k]         = shadow[k].blank;
         pub_invalid[k]       = shadow[k].invalid;
      end
   end

   // Input registers, stability counter, scan error and timeout counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // Idle values so the bus looks quiet (not a multi-select) straight out of reset.
         seg_q    <= 8'hFF;
         seg_p    <= 8'hFF;
         an_q     <= 4'hF;
         an_p     <= 4'hF;
         stab_cnt <= '0;
         to_cnt   <= '0;
         scan_err <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
         seg_q <= seven_segment;
         an_q  <= anode;
         seg_p <= seg_q;
         an_p  <= an_q;
         if (!same)
            stab_cnt <= CNT_W'(1);
         else if (stab_cnt != CNT_W'(STABLE_CYC))
            stab_cnt <= stab_cnt + CNT_W'(1);
         if (an_multi)
            scan_err <= 1'b1;
         if (accept)
            to_cnt <= '0;
         else if (to_cnt != TO_W'(TIMEOUT_CYC))
            to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign scan_stall = (to_cnt == TO_W'(TIMEOUT_CYC));

   // Frame FSM: collect accepted slots into shadows, publish when all four are in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_COLLECT;
         mask          <= 4'h0;
         pend_valid    <= 1'b0;
         pend_slot     <= 2'd0;
         pend_data     <= '0;
         // NOTE: the shadow array is small and is reset explicitly so a discarded partial frame can never leak out.
         for (int k = 0; k < 4; k++) shadow[k] <= '0;
         digits        <= 16'h0;
         dp            <= 4'h0;
         blank         <= 4'h0;
         invalid       <= 4'h0;
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
      end else begin
         frame_valid   <= 1'b0;
         frame_changed <= 1'b0;
         if (state == ST_PUBLISH) begin
            digits        <= pub_digits;
            dp            <= pub_dp;
            blank         <= pub_blank;
            invalid       <= pub_invalid;
            frame_valid   <= 1'b1;
            frame_changed <= {pub_digits, pub_dp, pub_blank, pub_invalid} !=
                             {digits, dp, blank, invalid};
            mask          <= 4'h0;
            state         <= ST_COLLECT;
            // An accept arriving while publishing is parked for the next cycle.
            if (accept) begin
               pend_valid <= 1'b1;
               pend_slot  <= acc_slot;
               pend_data  <= acc_data;
            end
         end else begin
            if (apply_pend) begin
               shadow[pend_slot] <= pend_data;
               pend_valid        <= 1'b0;
            end
            // A fresh accept is applied after the parked one: latest wins.
            if (apply_acc)
               shadow[acc_slot] <= acc_data;
            mask <= mask_nxt;
            if (go_publish)
               state <= ST_PUBLISH;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder. Expected frames are queued as
// each scan is driven; a monitor pops and compares on every frame_valid.
module tb_seg_scan_decoder;

   localparam int TO_CYC = 300;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  seven_segment;
   logic [3:0]  anode;
   logic [15:0] digits;
   logic [3:0]  dp, blank, invalid;
   logic        frame_valid, frame_changed, scan_err, scan_stall;

   seg_scan_decoder #(
      .STABLE_CYC (4),
      .CNT_W      (8),
      .TIMEOUT_CYC(TO_CYC),
      .TO_W       (18)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .seven_segment(seven_segment),
      .anode        (anode),
      .digits       (digits),
      .dp           (dp),
      .blank        (blank),
      .invalid      (invalid),
      .frame_valid  (frame_valid),
      .frame_changed(frame_changed),
      .scan_err     (scan_err),
      .scan_stall   (scan_stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [3:0]  invalid;
      logic        changed;
   } frame_t;

   frame_t sb[$];
   frame_t last_exp = '0;
   frame_t mon_f;
   int     checks   = 0;
   int     failures = 0;
   int     frames   = 0;
   int     frames_before;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Queue the frame the next complete scan should publish.
   task automatic expect_frame(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] b, input logic [3:0] i);
      frame_t f;
      f.digits  = d;
      f.dp      = p;
      f.blank   = b;
      f.invalid = i;
      f.changed = ({d, p, b, i} != {last_exp.digits, last_exp.dp, last_exp.blank, last_exp.invalid});
      last_exp  = f;
      sb.push_back(f);
   endtask

   task automatic drive(input int slot, input logic [7:0] seg, input int n);
      anode         = 4'hF;
      anode[slot]   = 1'b0;
      seven_segment = seg;
      repeat (n) @(negedge clk);
   endtask

   task automatic idle(input int n);
      anode         = 4'hF;
      seven_segment = 8'hFF;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while (sb.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      check(tag, sb.size(), 0);
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_digits"}, digits, 16'h0);
      check({tag, "_flags"}, {dp, blank, invalid}, 12'h0);
      check({tag, "_pulses"}, {frame_valid, frame_changed}, 2'b00);
      check({tag, "_scan_err"}, scan_err, 1'b0);
   endtask

   // Scoreboard monitor: every published frame must match the oldest expectation.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         frames++;
         check("frame_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_f = sb.pop_front();
            check("digits", digits, mon_f.digits);
            check("dp", dp, mon_f.dp);
            check("blank", blank, mon_f.blank);
            check("invalid", invalid, mon_f.invalid);
            check("frame_changed", frame_changed, mon_f.changed);
         end
      end
   end

   initial begin
      rst           = 1'b0;
      anode         = 4'hF;
      seven_segment = 8'hFF;
      repeat (3) @(negedge clk);

      // 1. reset state, then stall timeout on an idle bus
      check_cleared("rst");
      check("rst_stall", scan_stall, 1'b0);
      rst = 1'b1;
      repeat (TO_CYC - 10) @(negedge clk);
      check("stall_early", scan_stall, 1'b0);
      repeat (20) @(negedge clk);
      check("stall_set", scan_stall, 1'b1);
      check("no_frames_idle", frames, 0);

      // 2. basic scan 0..3, then the same scan again
      expect_frame(16'h3210, 4'h0, 4'h0, 4'h0);
      drive(0, 8'hC0, 8); drive(1, 8'hF9, 8); drive(2, 8'hA4, 8); drive(3, 8'hB0, 8);
      idle(4);
      drain("scan1_drain");
      check("stall_cleared", scan_stall, 1'b0);
      check("scan1_frames", frames, 1);
      expect_frame(16'h3210, 4'h0, 4'h0, 4'h0);
      drive(0, 8'hC0, 8); drive(1, 8'hF9, 8); drive(2, 8'hA4, 8); drive(3, 8'hB0, 8);
      idle(4);
      drain("scan2_drain");

      // 3. short glitch on the slot that completes the frame is ignored
      expect_frame(16'h6514, 4'h0, 4'h0, 4'h0);
      drive(0, 8'h99, 8); drive(2, 8'h92, 8); drive(3, 8'h82, 8);
      drive(1, 8'h55, 3); drive(1, 8'hF9, 8);
      idle(4);
      drain("glitch_drain");

      // 4. multi-select sets sticky scan_err and accepts nothing
      frames_before = frames;
      anode         = 4'b1100;
      seven_segment = 8'hC0;
      repeat (10) @(negedge clk);
      check("scan_err_set", scan_err, 1'b1);
      drive(0, 8'hC0, 8); drive(1, 8'hF9, 8); drive(2, 8'hA4, 8);
      idle(6);
      check("scan_err_sticky", scan_err, 1'b1);
      check("multi_no_accept", frames - frames_before, 0);
      rst = 1'b0;
      @(negedge clk);
      check_cleared("rst2");
      rst      = 1'b1;
      last_exp = '0;
      idle(2);

      // 5. blank slot, dp and a hex glyph
`ifdef SEG_DECODE_HEX_EN
      expect_frame(16'hA010, 4'b1000, 4'b0100, 4'b0000);
`else
      expect_frame(16'hF010, 4'b1000, 4'b0100, 4'b1000);
`endif
      drive(0, 8'hC0, 8); drive(1, 8'hF9, 8); drive(2, 8'hFF, 8); drive(3, 8'h08, 8);
      idle(4);
      drain("blank_hex_drain");

      // 6. reset mid-frame discards the partial frame
      drive(0, 8'h92, 8); drive(1, 8'h82, 8);
      anode = 4'hF;
      rst   = 1'b0;
      repeat (2) @(negedge clk);
      rst      = 1'b1;
      last_exp = '0;
      frames_before = frames;
      expect_frame(16'h0987, 4'h0, 4'h0, 4'h0);
      drive(0, 8'hF8, 8); drive(1, 8'h80, 8); drive(2, 8'h90, 8); drive(3, 8'hC0, 8);
      idle(6);
      drain("midreset_drain");
      check("midreset_frames", frames - frames_before, 1);

      // 7. re-accepting a slot before the frame completes: latest wins
      expect_frame(16'h5439, 4'h0, 4'h0, 4'h0);
      drive(0, 8'hA4, 8); drive(1, 8'hB0, 8); drive(0, 8'h90, 8);
      drive(2, 8'h99, 8); drive(3, 8'h92, 8);
      idle(4);
      drain("overwrite_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
